// File: rtl/if_id_pkg.sv
// Shared constants, entry type and width helper for the IF/ID fetch queue.
package if_id_pkg;

  localparam int          XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] inst;
    logic [XLEN_DEFAULT-1:0] pc;
  } if_id_entry_t;

  // Occupancy needs to represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/if_id_ring_mem.sv
// Register array backing the IF/ID queue: one synchronous write port and one
// asynchronous read port. Pointer and occupancy control lives in the parent.
module if_id_ring_mem
  import if_id_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter int  AW      = 1,
  parameter type entry_t = if_id_entry_t
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  entry_t mem [DEPTH];

  // NOTE: storage is deliberately not reset; the occupancy count alone decides
  // what is valid, and leaving the array unreset keeps it in plain flops.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID fetch queue: DEPTH-entry circular buffer between fetch and decode with
// stall/flush on the decode side. Optional counters under IF_ID_QUEUE_PERF_EN.
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] NOP_INST = if_id_pkg::NOP_INST
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [XLEN-1:0]               in_inst,
  input  logic [XLEN-1:0]               in_pc,
  input  logic                          stall,
  input  logic                          flush,
  output logic                          out_valid,
  output logic [XLEN-1:0]               out_inst,
  output logic [XLEN-1:0]               out_pc,
`ifdef IF_ID_QUEUE_PERF_EN
  output logic [31:0]                   perf_stall_cycles,
  output logic [31:0]                   perf_flush_count,
`endif
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int                CW         = count_width(DEPTH);
  localparam int                PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]     FULL_COUNT = CW'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          push;
  logic          pop;
  entry_t        wdata;
  entry_t        head_entry;

  // Power-of-two depth wraps by natural overflow; a single entry never moves.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (DEPTH == 1) ? '0 : p + 1'b1;
  endfunction

  // in_ready depends on registered count only, never on stall or flush.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && !stall && !flush;
  assign wdata     = '{inst: in_inst, pc: in_pc};

  if_id_ring_mem #(
    .DEPTH   (DEPTH),
    .AW      (PW),
    .entry_t (entry_t)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (tail),
    .wdata (wdata),
    .raddr (head),
    .rdata (head_entry)
  );

  assign out_inst = out_valid ? head_entry.inst : NOP_INST;
  assign out_pc   = out_valid ? head_entry.pc   : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

`ifdef IF_ID_QUEUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (stall && out_valid && !flush && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (flush && (perf_flush_count != '1))
        perf_flush_count <= perf_flush_count + 1'b1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n) count <= FULL_COUNT);
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: vector table on a DEPTH=2 instance, scoreboard-driven
// streaming and wrap-around on a DEPTH=4 instance, plus reset and perf sequences.
module tb_if_id_queue;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DEPTH=2 instance
  logic        v2, st2, fl2, rdy2, ov2;
  logic [31:0] inst2, pc2, oi2, op2;
  logic [1:0]  cnt2;
  // DEPTH=4 instance
  logic        v4, st4, fl4, rdy4, ov4;
  logic [31:0] inst4, pc4, oi4, op4;
  logic [2:0]  cnt4;
`ifdef IF_ID_QUEUE_PERF_EN
  logic [31:0] ps2, pf2, ps4, pf4;
`endif

  int total = 0;
  int bad   = 0;

  if_id_queue #(.XLEN(32), .DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v2), .in_ready(rdy2), .in_inst(inst2), .in_pc(pc2),
    .stall(st2), .flush(fl2),
    .out_valid(ov2), .out_inst(oi2), .out_pc(op2),
`ifdef IF_ID_QUEUE_PERF_EN
    .perf_stall_cycles(ps2), .perf_flush_count(pf2),
`endif
    .count(cnt2)
  );

  if_id_queue #(.XLEN(32), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v4), .in_ready(rdy4), .in_inst(inst4), .in_pc(pc4),
    .stall(st4), .flush(fl4),
    .out_valid(ov4), .out_inst(oi4), .out_pc(op4),
`ifdef IF_ID_QUEUE_PERF_EN
    .perf_stall_cycles(ps4), .perf_flush_count(pf4),
`endif
    .count(cnt4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive the DEPTH=2 inputs for one cycle and sample #1 after the edge.
  task automatic tick2(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic st, input logic fl);
    v2 = v; inst2 = inst; pc2 = pc; st2 = st; fl2 = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_empty2(input string tag);
    check({tag, " valid"}, 32'(ov2), 32'd0);
    check({tag, " inst"},  oi2, 32'h0000_0013);
    check({tag, " pc"},    op2, 32'd0);
    check({tag, " count"}, 32'(cnt2), 32'd0);
    check({tag, " ready"}, 32'(rdy2), 32'd1);
  endtask

  typedef struct {
    logic        v;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        st;
    logic        fl;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    int          e_count;
    logic        e_ready;
  } vec_t;

  vec_t tbl[17];

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   popped;

  // One DEPTH=4 cycle: check head against the scoreboard, update it, clock.
  task automatic sb_cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                          input logic st, output logic accepted);
    exp_t e;
    logic model_ready;
    logic do_pop;
    v4 = v; inst4 = inst; pc4 = pc; st4 = st; fl4 = 1'b0;
    model_ready = (sb.size() < 4);
    check("d4 ready", 32'(rdy4), 32'(model_ready));
    check("d4 valid", 32'(ov4), 32'(sb.size() != 0));
    do_pop = (sb.size() != 0) && !st;
    if (do_pop) begin
      e = sb.pop_front();
      check("d4 head pc", op4, e.pc);
      check("d4 head inst", oi4, e.inst);
      popped++;
    end
    accepted = v && model_ready;
    if (accepted) sb.push_back('{inst: inst, pc: pc});
    @(posedge clk);
    #1;
    check("d4 count", 32'(cnt4), 32'(sb.size()));
    check("d4 count bound", 32'(cnt4 <= 3'd4), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   pushed;
    int   cyc;

    tbl[0]  = '{1'b1, 32'h0050_0093, 32'h00, 1'b1, 1'b0, 1'b1, 32'h0050_0093, 32'h00, 1, 1'b1};
    tbl[1]  = '{1'b1, 32'h00A0_0113, 32'h04, 1'b1, 1'b0, 1'b1, 32'h0050_0093, 32'h00, 2, 1'b0};
    tbl[2]  = '{1'b1, 32'h0010_0193, 32'h08, 1'b1, 1'b0, 1'b1, 32'h0050_0093, 32'h00, 2, 1'b0};
    tbl[3]  = '{1'b0, 32'h0,         32'h00, 1'b0, 1'b0, 1'b1, 32'h00A0_0113, 32'h04, 1, 1'b1};
    tbl[4]  = '{1'b0, 32'h0,         32'h00, 1'b0, 1'b0, 1'b0, 32'h0000_0013, 32'h00, 0, 1'b1};
    tbl[5]  = '{1'b0, 32'h0,         32'h00, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'h00, 0, 1'b1};
    tbl[6]  = '{1'b1, 32'h0020_0213, 32'h10, 1'b1, 1'b0, 1'b1, 32'h0020_0213, 32'h10, 1, 1'b1};
    tbl[7]  = '{1'b1, 32'h0030_0293, 32'h14, 1'b1, 1'b0, 1'b1, 32'h0020_0213, 32'h10, 2, 1'b0};
    tbl[8]  = '{1'b1, 32'h0040_0313, 32'h20, 1'b1, 1'b1, 1'b0, 32'h0000_0013, 32'h00, 0, 1'b1};
    tbl[9]  = '{1'b1, 32'h0050_0393, 32'h24, 1'b0, 1'b1, 1'b0, 32'h0000_0013, 32'h00, 0, 1'b1};
    tbl[10] = '{1'b0, 32'h0,         32'h00, 1'b0, 1'b0, 1'b0, 32'h0000_0013, 32'h00, 0, 1'b1};
    tbl[11] = '{1'b1, 32'h0060_0413, 32'h30, 1'b1, 1'b0, 1'b1, 32'h0060_0413, 32'h30, 1, 1'b1};
    tbl[12] = '{1'b1, 32'h0070_0493, 32'h34, 1'b1, 1'b0, 1'b1, 32'h0060_0413, 32'h30, 2, 1'b0};
    tbl[13] = '{1'b1, 32'h0080_0513, 32'h38, 1'b0, 1'b0, 1'b1, 32'h0070_0493, 32'h34, 1, 1'b1};
    tbl[14] = '{1'b0, 32'h0,         32'h00, 1'b0, 1'b0, 1'b0, 32'h0000_0013, 32'h00, 0, 1'b1};
    tbl[15] = '{1'b1, 32'h0090_0593, 32'h40, 1'b0, 1'b0, 1'b1, 32'h0090_0593, 32'h40, 1, 1'b1};
    tbl[16] = '{1'b0, 32'h0,         32'h00, 1'b0, 1'b1, 1'b0, 32'h0000_0013, 32'h00, 0, 1'b1};

    rst_n = 1'b0;
    v2 = 1'b0; inst2 = '0; pc2 = '0; st2 = 1'b0; fl2 = 1'b0;
    v4 = 1'b0; inst4 = '0; pc4 = '0; st4 = 1'b0; fl4 = 1'b0;
    popped = 0;
    #2;
    check_empty2("reset");
    #1 rst_n = 1'b1;

    // Fill/drain, full-blocked push, stall on empty, flush priority, no refill.
    for (int i = 0; i < 17; i++) begin
      tick2(tbl[i].v, tbl[i].inst, tbl[i].pc, tbl[i].st, tbl[i].fl);
      check($sformatf("row%0d valid", i), 32'(ov2), 32'(tbl[i].e_valid));
      check($sformatf("row%0d inst", i),  oi2, tbl[i].e_inst);
      check($sformatf("row%0d pc", i),    op2, tbl[i].e_pc);
      check($sformatf("row%0d count", i), 32'(cnt2), 32'(tbl[i].e_count));
      check($sformatf("row%0d ready", i), 32'(rdy2), 32'(tbl[i].e_ready));
    end

    // Asynchronous reset in the middle of a cycle with two entries held.
    tick2(1'b1, 32'h00B0_0613, 32'h50, 1'b1, 1'b0);
    tick2(1'b1, 32'h00C0_0693, 32'h54, 1'b1, 1'b0);
    v2 = 1'b0; st2 = 1'b0;
    check("pre-reset count", 32'(cnt2), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check_empty2("midrun reset");
    #1 rst_n = 1'b1;

`ifdef IF_ID_QUEUE_PERF_EN
    check("perf stall reset", ps2, 32'd0);
    check("perf flush reset", pf2, 32'd0);
    tick2(1'b1, 32'h00D0_0713, 32'h60, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick2(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick2(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    tick2(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick2(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("perf stall cycles", ps2, 32'd3);
    check("perf flush count", pf2, 32'd2);
`endif

    // Streaming: one push and one pop per cycle keeps occupancy at one.
    for (int i = 0; i < 8; i++) begin
      sb_cycle(1'b1, 32'h0000_0093 | (32'(i) << 20), 32'(i) * 4, 1'b0, acc);
      check("stream count", 32'(cnt4), 32'd1);
      check("stream out pc lags in pc", op4, 32'(i) * 4);
    end
    sb_cycle(1'b0, 32'h0, 32'h0, 1'b0, acc);

    // Wrap-around: ten entries through four slots with random stall.
    pushed = 0;
    popped = 0;
    cyc    = 0;
    while ((pushed < 10 || sb.size() != 0) && cyc < 300) begin
      sb_cycle(pushed < 10, 32'h0000_0113 | (32'(pushed) << 20),
               32'h100 + 32'(pushed) * 4, 1'($urandom_range(0, 1)), acc);
      if (acc) pushed++;
      cyc++;
    end
    check("wrap entries popped", 32'(popped), 32'd10);
    check("wrap final count", 32'(cnt4), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
